avalon_main_pipeline_bridge: RTL

Registered Avalon-MM pipeline bridge between the core wrapper's data master port and the system interconnect. It adds a command register with a skid buffer to break long timing paths. It enforces a bounded number of outstanding reads with a credit counter and registers read responses. A read watchdog synthesizes an error response when the fabric never answers, so the core cannot hang on a lost read.

---
 rtl/avalon_main_pipeline_bridge.sv | 127 ++++++++++++
 1 files changed

// File: rtl/avalon_main_pipeline_bridge.sv
// Registered Avalon-MM bridge: command register with skid buffer, read credit
// counter, registered read responses and a read watchdog that synthesizes SLVERR.
module avalon_main_pipeline_bridge #(
  parameter int MAX_PENDING = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] s_address,
  input  logic [3:0]  s_byteenable,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic [1:0]  s_response,
  output logic [31:0] m_address,
  output logic [3:0]  m_byteenable,
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  input  logic [1:0]  m_response,
  output logic [3:0]  pending_o
);

  localparam int              TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [3:0]      MAX_P = 4'(MAX_PENDING);
  localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t          in_cmd, skid_cmd_p0, main_cmd_p1;
  logic          skid_v, main_v;
  logic [3:0]    pending_q, issued_q, drop_q;
  logic [TW-1:0] timer_q;
  logic          accept, accept_rd, fire, live, expire, take_rsp;

  assign in_cmd        = {s_read, s_write, s_address, s_byteenable, s_writedata};
  assign s_waitrequest = skid_v | (s_read & (pending_q == MAX_P));
  assign accept        = (s_read | s_write) & ~s_waitrequest;
  assign accept_rd     = accept & s_read;
  assign fire          = main_v & ~m_waitrequest;

  // Stage p0 -> p1: skid buffer feeding the main command register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_v      <= 1'b0;
      main_cmd_p1 <= '0;
      skid_v      <= 1'b0;
      skid_cmd_p0 <= '0;
    end else begin
      if (fire || !main_v) begin
        if (skid_v) begin
          main_cmd_p1 <= skid_cmd_p0;
          main_v      <= 1'b1;
        end else if (accept) begin
          main_cmd_p1 <= in_cmd;
          main_v      <= 1'b1;
        end else begin
          main_v      <= 1'b0;
        end
      end
      if (skid_v && fire) begin
        skid_v <= 1'b0;
      end else if (accept && main_v && !fire) begin
        skid_v      <= 1'b1;
        skid_cmd_p0 <= in_cmd;
      end
    end
  end

  assign m_read       = main_v & main_cmd_p1.rd;
  assign m_write      = main_v & main_cmd_p1.wr;
  assign m_address    = main_cmd_p1.addr;
  assign m_byteenable = main_cmd_p1.be;
  assign m_writedata  = main_cmd_p1.wdata;
  assign pending_o    = pending_q;

  // A read is live once issued and not yet written off by the watchdog
  assign live     = (issued_q != drop_q);
  assign expire   = (TIMEOUT != 0) && live && !m_readdatavalid && (timer_q == TLAST);
  assign take_rsp = m_readdatavalid & (drop_q == 4'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= 4'd0;
      issued_q  <= 4'd0;
      drop_q    <= 4'd0;
      timer_q   <= '0;
    end else begin
      pending_q <= pending_q + 4'(accept_rd) - 4'(m_readdatavalid);
      issued_q  <= issued_q + 4'(fire & main_cmd_p1.rd) - 4'(m_readdatavalid);
      drop_q    <= drop_q + 4'(expire) - 4'(m_readdatavalid & (drop_q != 4'd0));
      if (!live || m_readdatavalid || expire) timer_q <= '0;
      else                                    timer_q <= timer_q + TW'(1);
    end
  end

  // Stage p1 -> upstream: registered response, fabric beats take priority over timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_readdatavalid <= 1'b0;
      s_readdata      <= '0;
      s_response      <= 2'b00;
    end else begin
      s_readdatavalid <= take_rsp | expire;
      if (take_rsp) begin
        s_readdata <= m_readdata;
        s_response <= m_response;
      end else if (expire) begin
        s_readdata <= '0;
        s_response <= 2'b10;
      end
    end
  end

endmodule
